fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time and
// presents the returned word to the decoder through a one-entry ir/pc_out buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    output logic [31:0] pc_out,
    output logic        ir_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] req_addr_reg;
    logic [31:0] ir_reg;
    logic [31:0] pc_out_reg;
    logic        ir_valid_reg;
    logic        imem_req_reg;

    logic [31:0] redirect_pc;
    logic        buffer_free;

    assign redirect_pc = branch_target & ~32'h3;
    // The buffer can take a new word once the decoder has consumed (or never had) the current one.
    assign buffer_free = !ir_valid_reg || !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC_ALIGNED;
            req_addr_reg <= RESET_PC_ALIGNED;
            ir_reg       <= NOP_INSTR;
            pc_out_reg   <= 32'h0000_0000;
            ir_valid_reg <= 1'b0;
            imem_req_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (branch_taken) begin
                        pc_reg       <= redirect_pc;
                        ir_valid_reg <= 1'b0;
                    end else if (buffer_free) begin
                        req_addr_reg <= pc_reg;
                        ir_valid_reg <= 1'b0;
                        state_reg    <= WAIT;
                        imem_req_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (branch_taken) begin
                        pc_reg       <= redirect_pc;
                        ir_valid_reg <= 1'b0;
                        // A still-pending response belongs to the old path and must be dropped.
                        if (imem_ready) begin
                            state_reg    <= IDLE;
                            imem_req_reg <= 1'b0;
                        end else begin
                            state_reg    <= DRAIN;
                        end
                    end else if (imem_ready) begin
                        ir_reg       <= imem_data;
                        pc_out_reg   <= req_addr_reg;
                        ir_valid_reg <= 1'b1;
                        pc_reg       <= pc_reg + 32'd4;
                        state_reg    <= IDLE;
                        imem_req_reg <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (branch_taken) begin
                        pc_reg       <= redirect_pc;
                        ir_valid_reg <= 1'b0;
                    end
                    if (imem_ready) begin
                        state_reg    <= IDLE;
                        imem_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    imem_req_reg <= 1'b0;
                    ir_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_reg;
    assign imem_addr = req_addr_reg;
    assign ir        = ir_reg;
    assign pc_out    = pc_out_reg;
    assign ir_valid  = ir_valid_reg;

endmodule
